// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: a serial per-voice search followed by a single commit
// that retriggers a matching voice, claims a free voice, or steals the oldest allocation.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int FREQ_W     = 32
) (
    input  logic                         Sys_clk,
    input  logic                         Alloc_rst,
    input  logic                         Ev_valid,
    output logic                         Ev_ready,
    input  logic                         Ev_on,
    input  logic [NOTE_W-1:0]            Ev_note,
    input  logic [FREQ_W-1:0]            Ev_freq,
    output logic [NUM_VOICES*FREQ_W-1:0] Freq,
    output logic [NUM_VOICES-1:0]        Gate,
    output logic [NUM_VOICES-1:0]        Voice_rst,
    output logic                         Steal
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_COMMIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_search;
    logic                  w_commit;

    logic                  r_ready;
    logic                  r_ev_on;
    logic [NOTE_W-1:0]     r_ev_note;
    logic [FREQ_W-1:0]     r_ev_freq;

    logic [IDX_W-1:0]      r_idx;
    logic                  r_match_vld;
    logic                  r_free_vld;
    logic [IDX_W-1:0]      r_match_idx;
    logic [IDX_W-1:0]      r_free_idx;
    logic [IDX_W-1:0]      r_old_idx;

    logic [NUM_VOICES-1:0] r_gate;
    logic [NOTE_W-1:0]     r_note [NUM_VOICES];
    logic [FREQ_W-1:0]     r_freq [NUM_VOICES];
    logic [IDX_W-1:0]      r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_voice_rst;
    logic                  r_steal;

    logic                  w_cur_match;
    logic                  w_cur_free;
    logic                  w_cur_old;
    logic [IDX_W-1:0]      w_target;
    logic                  w_do_alloc;
    logic                  w_do_release;
    logic                  w_is_steal;

    assign w_accept = Ev_valid && r_ready;

    always_ff @(posedge Sys_clk or negedge Alloc_rst) begin
        if (!Alloc_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_search    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                w_search = 1'b1;
                if (r_idx == LAST_IDX) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered so that ready stays low for one idle cycle after a commit.
    always_ff @(posedge Sys_clk or negedge Alloc_rst) begin
        if (!Alloc_rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == ST_IDLE) && !w_accept;
        end
    end

    assign w_cur_match = r_gate[r_idx] && (r_note[r_idx] == r_ev_note);
    assign w_cur_free  = !r_gate[r_idx];
    assign w_cur_old   = (r_age[r_idx] == LAST_IDX);

    always_ff @(posedge Sys_clk or negedge Alloc_rst) begin
        if (!Alloc_rst) begin
            r_ev_on     <= 1'b0;
            r_ev_note   <= '0;
            r_ev_freq   <= '0;
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
            r_match_idx <= '0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
        end else if (w_accept) begin
            r_ev_on     <= Ev_on;
            r_ev_note   <= Ev_note;
            r_ev_freq   <= Ev_freq;
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
        end else if (w_search) begin
            r_idx <= r_idx + 1'b1;
            if (w_cur_match && !r_match_vld) begin
                r_match_vld <= 1'b1;
                r_match_idx <= r_idx;
            end
            if (w_cur_free && !r_free_vld) begin
                r_free_vld <= 1'b1;
                r_free_idx <= r_idx;
            end
            if (w_cur_old) r_old_idx <= r_idx;
        end
    end

    always_comb begin
        w_target     = r_old_idx;
        w_do_alloc   = 1'b0;
        w_do_release = 1'b0;
        w_is_steal   = 1'b0;
        if (w_commit) begin
            if (r_ev_on) begin
                w_do_alloc = 1'b1;
                if (r_match_vld) begin
                    w_target = r_match_idx;
                end else if (r_free_vld) begin
                    w_target = r_free_idx;
                end else begin
                    w_target   = r_old_idx;
                    w_is_steal = 1'b1;
                end
            end else if (r_match_vld) begin
                w_do_release = 1'b1;
                w_target     = r_match_idx;
            end
        end
    end

    // Ages stay a permutation: only voices younger than the target move up by one.
    always_ff @(posedge Sys_clk or negedge Alloc_rst) begin
        if (!Alloc_rst) begin
            r_gate      <= '0;
            r_voice_rst <= '0;
            r_steal     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_freq[i] <= '0;
                r_age[i]  <= IDX_W'(i);
            end
        end else begin
            r_voice_rst <= '0;
            r_steal     <= w_is_steal;
            if (w_do_alloc) begin
                r_gate[w_target]      <= 1'b1;
                r_note[w_target]      <= r_ev_note;
                r_freq[w_target]      <= r_ev_freq;
                r_voice_rst[w_target] <= 1'b1;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == w_target) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] < r_age[w_target]) begin
                        r_age[i] <= r_age[i] + 1'b1;
                    end
                end
            end else if (w_do_release) begin
                r_gate[w_target] <= 1'b0;
            end
        end
    end

    always_comb begin
        Freq = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            Freq[i*FREQ_W +: FREQ_W] = r_freq[i];
        end
    end

    assign Gate      = r_gate;
    assign Voice_rst = r_voice_rst;
    assign Steal     = r_steal;
    assign Ev_ready  = r_ready;

endmodule
